// File: rtl/common.sv
// Shared types for the execute stage: control word, ALU and M-extension opcodes,
// multiply/divide FSM states and the operand forward-select codes.
package common;

  localparam logic [1:0] No_forward       = 2'b00;
  localparam logic [1:0] Forward_from_ex  = 2'b01;
  localparam logic [1:0] Forward_from_mem = 2'b10;

  typedef enum logic [2:0] {
    MD_MUL = 3'd0, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instr_type_t;

  typedef struct packed {
    instr_type_t instr_type;
    alu_op_t     alu_op;
    logic        alu_src;
    logic [2:0]  funct3;
    logic        jump;
    logic        jalr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } control_type;

  // Upper opcode bit separates the divide/remainder group from the multiplies.
  function automatic logic is_div_op(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU for the base instruction set.
module alu
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t          alu_op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:   result = XLEN'(a < b);
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = XLEN'($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// M-extension unit: pipelined multiplier of MUL_CYCLES stages and a radix-2
// restoring divider taking XLEN cycles, sequenced by an IDLE/MUL/DIV/DONE FSM.
module muldiv_unit
  import common::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             start,
  input  md_op_t           op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output md_state_t        state,
  output logic             accept,
  output logic             busy,
  output logic [XLEN-1:0]  result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  md_op_t           op_reg;
  logic [XLEN-1:0]  a_reg, b_reg, quot_reg, rem_reg, dvsr_reg;
  logic [XLEN-1:0]  quot_next, rem_next;
  logic [XLEN:0]    shifted, diff;
  logic             div_signed_in, div_signed, neg_q, neg_r;
  logic             a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, product, prod_last;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  assign state  = state_reg;
  assign accept = reset_n & ~flush & start & (state_reg == IDLE);
  assign busy   = reset_n & (accept | (state_reg == MUL) | (state_reg == DIV));
  assign div_signed_in = (op == MD_DIV) || (op == MD_REM);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = is_div_op(op) ? DIV : MUL;
      MUL:  if (cnt_reg == MUL_LAST) state_next = DONE;
      DIV:  if (cnt_reg == DIV_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  assign shifted = {rem_reg, quot_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_reg};

  always_comb begin
    if (diff[XLEN]) begin
      rem_next  = shifted[XLEN-1:0];
      quot_next = {quot_reg[XLEN-2:0], 1'b0};
    end else begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot_reg[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= MD_MUL;
      a_reg     <= '0;
      b_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg  <= '0;
        op_reg   <= op;
        a_reg    <= a;
        b_reg    <= b;
        quot_reg <= mag(a, div_signed_in);
        rem_reg  <= '0;
        dvsr_reg <= mag(b, div_signed_in);
      end else begin
        if (state_reg == MUL || state_reg == DIV) cnt_reg <= cnt_reg + 1'b1;
        if (state_reg == DIV) begin
          quot_reg <= quot_next;
          rem_reg  <= rem_next;
        end
      end
    end
  end

  // Sign-extending to 2*XLEN makes a plain multiply yield the right signed product.
  assign a_sgn   = ((op_reg == MD_MULH) || (op_reg == MD_MULHSU)) & a_reg[XLEN-1];
  assign b_sgn   = (op_reg == MD_MULH) & b_reg[XLEN-1];
  assign a_ext   = {{XLEN{a_sgn}}, a_reg};
  assign b_ext   = {{XLEN{b_sgn}}, b_reg};
  assign product = a_ext * b_ext;

  for (genvar gi = 0; gi < MUL_CYCLES; gi++) begin : g_stage
    logic [2*XLEN-1:0] stage_reg;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        stage_reg <= '0;
      end else if (state_reg == MUL) begin
        if (gi == 0) stage_reg <= product;
        else         stage_reg <= g_stage[(gi > 0) ? gi - 1 : 0].stage_reg;
      end
    end
  end
  assign prod_last = g_stage[MUL_CYCLES-1].stage_reg;

  assign div_signed = (op_reg == MD_DIV) || (op_reg == MD_REM);
  assign neg_q      = div_signed & (a_reg[XLEN-1] ^ b_reg[XLEN-1]);
  assign neg_r      = div_signed & a_reg[XLEN-1];

  always_comb begin
    result = '0;
    case (op_reg)
      MD_MUL:                       result = prod_last[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_last[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:  result = (b_reg == '0) ? '1 : (neg_q ? -quot_reg : quot_reg);
      MD_REM, MD_REMU:  result = (b_reg == '0) ? a_reg : (neg_r ? -rem_reg : rem_reg);
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: forwarding, ALU, branch/jump resolution, and a multi-cycle
// multiply/divide path that stalls upstream until its result retires.
module execute_stage_md
  import common::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [XLEN-1:0]  immediate_data,
  input  logic [XLEN-1:0]  pc_in,
  input  control_type      control_in,
  output control_type      control_out,
  input  logic             md_en,
  input  md_op_t           md_op,
  input  logic [XLEN-1:0]  mem_forward_data,
  input  logic [XLEN-1:0]  wb_forward_data,
  input  logic [1:0]       forward_rs1,
  input  logic [1:0]       forward_rs2,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [XLEN-1:0]  alu_data,
  output logic [XLEN-1:0]  memory_data,
  output logic             pc_src,
  output logic             jalr_flag,
  output logic [XLEN-1:0]  jalr_target_offset,
  output logic [XLEN-1:0]  pc_out
);

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_result, jt_sum, md_result;
  logic [XLEN-1:0] pc_reg, store_reg;
  control_type     ctrl_reg;
  md_state_t       md_state;
  logic            md_accept, md_busy, taken;

  always_comb begin
    case (forward_rs1)
      Forward_from_ex:  op_a = mem_forward_data;
      Forward_from_mem: op_a = wb_forward_data;
      default:          op_a = data1;
    endcase
    case (forward_rs2)
      Forward_from_ex:  rs2_fwd = mem_forward_data;
      Forward_from_mem: rs2_fwd = wb_forward_data;
      default:          rs2_fwd = data2;
    endcase
  end
  assign op_b = control_in.alu_src ? immediate_data : rs2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .alu_op (control_in.alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_md (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .start   (in_valid & md_en),
    .op      (md_op),
    .a       (op_a),
    .b       (rs2_fwd),
    .state   (md_state),
    .accept  (md_accept),
    .busy    (md_busy),
    .result  (md_result)
  );

  always_comb begin
    case (control_in.funct3)
      3'b000:  taken = (op_a == rs2_fwd);
      3'b001:  taken = (op_a != rs2_fwd);
      3'b100:  taken = ($signed(op_a) <  $signed(rs2_fwd));
      3'b101:  taken = ($signed(op_a) >= $signed(rs2_fwd));
      3'b110:  taken = (op_a <  rs2_fwd);
      3'b111:  taken = (op_a >= rs2_fwd);
      default: taken = 1'b0;
    endcase
  end
  assign jt_sum = op_a + immediate_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_reg  <= '0;
      pc_reg    <= '0;
      store_reg <= '0;
    end else if (md_accept) begin
      ctrl_reg  <= control_in;
      pc_reg    <= pc_in;
      store_reg <= rs2_fwd;
    end
  end

  // The retiring M-op is presented entirely from the copy latched at acceptance.
  always_comb begin
    control_out        = control_in;
    alu_data           = control_in.jump ? pc_in + XLEN'(4) : alu_result;
    memory_data        = rs2_fwd;
    pc_src             = (control_in.instr_type == B_TYPE) & taken & ~md_en;
    jalr_flag          = control_in.jalr & ~md_en;
    jalr_target_offset = {jt_sum[XLEN-1:1], 1'b0};
    pc_out             = pc_in;
    out_valid          = in_valid & ~md_en & (md_state == IDLE);
    if (md_state == DONE) begin
      control_out        = ctrl_reg;
      alu_data           = md_result;
      memory_data        = store_reg;
      pc_src             = 1'b0;
      jalr_flag          = 1'b0;
      jalr_target_offset = '0;
      pc_out             = pc_reg;
      out_valid          = 1'b1;
    end
    out_valid = out_valid & reset_n & ~flush;
  end

  assign stall = md_busy;

endmodule
